// File: rtl/elevator_scheduler.sv
// elevator_scheduler: SCAN-policy request scheduler for a 4-floor elevator car.
// It latches floor calls, picks the next target floor, times the door dwell and
// handles the emergency stop. The elevator FSM moves the car and reports cur_floor.
// Optional feature: define SERVICE_COUNT_EN to add the 8-bit served_count output.

module elevator_scheduler #(
    parameter int DOOR_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       stop,
    input  logic [3:0] call,
    input  logic [1:0] cur_floor,
    output logic [1:0] target,
    output logic       target_valid,
    output logic       dir_up,
    output logic       door_open,
    output logic [3:0] pending
`ifdef SERVICE_COUNT_EN
    ,
    output logic [7:0] served_count
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR_OPEN,
        HALT
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] timer;
    logic [1:0] next_target;
    logic       next_dir;

    logic       above_any;
    logic [1:0] above_near;
    logic       below_any;
    logic [1:0] below_near;
    logic       here_pending;
    logic [3:0] floor_mask;
    logic [3:0] clr;
    logic       door_entry;

    // Find the nearest outstanding request above and below the car.
    always_comb begin
        above_any  = 1'b0;
        above_near = 2'd0;
        below_any  = 1'b0;
        below_near = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending[i] && (i > int'(cur_floor))) begin
                above_any  = 1'b1;
                above_near = 2'(i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (pending[i] && (i < int'(cur_floor))) begin
                below_any  = 1'b1;
                below_near = 2'(i);
            end
        end
    end

    assign here_pending = pending[cur_floor];
    assign floor_mask   = 4'b0001 << cur_floor;

    // Next-state, target and direction decision; stop overrides everything.
    always_comb begin
        next_state  = state;
        next_target = target;
        next_dir    = dir_up;
        case (state)
            IDLE: begin
                if (here_pending) begin
                    next_state = DOOR_OPEN;
                end else if (above_any && dir_up) begin
                    next_state  = MOVE_UP;
                    next_target = above_near;
                end else if (below_any) begin
                    next_state  = MOVE_DOWN;
                    next_target = below_near;
                    next_dir    = 1'b0;
                end else if (above_any) begin
                    next_state  = MOVE_UP;
                    next_target = above_near;
                    next_dir    = 1'b1;
                end
            end
            MOVE_UP: begin
                if (here_pending) begin
                    next_state  = DOOR_OPEN;
                    next_target = cur_floor;
                end else if (above_any) begin
                    next_target = above_near;
                end else begin
                    next_state = IDLE;
                end
            end
            MOVE_DOWN: begin
                if (here_pending) begin
                    next_state  = DOOR_OPEN;
                    next_target = cur_floor;
                end else if (below_any) begin
                    next_target = below_near;
                end else begin
                    next_state = IDLE;
                end
            end
            DOOR_OPEN: begin
                if (timer == 8'd0) begin
                    next_state = IDLE;
                end
            end
            HALT: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (stop) begin
            next_state  = HALT;
            next_target = target;
            next_dir    = dir_up;
        end
    end

    // The served floor is cleared on the entry cycle and for the whole dwell.
    assign door_entry = (next_state == DOOR_OPEN) && (state != DOOR_OPEN);
    assign clr = ((state == DOOR_OPEN) || (next_state == DOOR_OPEN)) ? floor_mask : 4'b0000;

    // State register with registered outputs, pending set/clear and door timer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            pending      <= 4'b0000;
            target       <= 2'd0;
            target_valid <= 1'b0;
            dir_up       <= 1'b1;
            door_open    <= 1'b0;
            timer        <= 8'd0;
`ifdef SERVICE_COUNT_EN
            served_count <= 8'd0;
`endif
        end else begin
            state        <= next_state;
            pending      <= (pending | call) & ~clr;
            target       <= next_target;
            dir_up       <= next_dir;
            target_valid <= (next_state == MOVE_UP) || (next_state == MOVE_DOWN);
            door_open    <= (next_state == DOOR_OPEN);
            if (door_entry) begin
                timer <= 8'(DOOR_CYCLES - 1);
            end else if ((state == DOOR_OPEN) && (next_state == DOOR_OPEN)) begin
                timer <= timer - 8'd1;
            end else begin
                timer <= 8'd0;
            end
`ifdef SERVICE_COUNT_EN
            if (door_entry) begin
                served_count <= served_count + 8'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: directed self-checking bench for elevator_scheduler.
// A tiny car model walks cur_floor toward the target; every door opening is
// checked against a queue of expected floors and for its dwell length.

module tb_elevator_scheduler;

    localparam int DOOR_CYCLES = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       stop;
    logic [3:0] call;
    logic [1:0] cur_floor;
    logic [1:0] target;
    logic       target_valid;
    logic       dir_up;
    logic       door_open;
    logic [3:0] pending;
`ifdef SERVICE_COUNT_EN
    logic [7:0] served_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [1:0] exp_doors[$];
    bit         prev_door = 1'b0;
    bit         len_valid = 1'b0;
    int         door_len  = 0;
    bit         move_phase = 1'b0;

    elevator_scheduler #(.DOOR_CYCLES(DOOR_CYCLES)) dut (
        .clock        (clock),
        .reset        (reset),
        .stop         (stop),
        .call         (call),
        .cur_floor    (cur_floor),
        .target       (target),
        .target_valid (target_valid),
        .dir_up       (dir_up),
        .door_open    (door_open),
        .pending      (pending)
`ifdef SERVICE_COUNT_EN
        ,
        .served_count (served_count)
`endif
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    // Compare one observed value against the bench's expectation.
    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one cycle worth of call/stop inputs and clock it in.
    task automatic apply_stimulus(input logic [3:0] c, input logic s);
        call = c;
        stop = s;
        tick();
    endtask

    // Let the car model run until every expected door service has happened.
    task automatic run_car(input int bound);
        bit done;
        done = 1'b0;
        for (int n = 0; n < bound && !done; n++) begin
            tick();
            if (target_valid && (cur_floor != target)) begin
                if (move_phase) begin
                    cur_floor = (target > cur_floor) ? 2'(cur_floor + 2'd1) : 2'(cur_floor - 2'd1);
                end
                move_phase = !move_phase;
            end
            if ((exp_doors.size() == 0) && !door_open && !target_valid) begin
                done = 1'b1;
            end
        end
        check_output("run_complete", 32'(done), 32'd1);
    endtask

    // Scoreboard: pop the expected floor on every door opening, check dwell length.
    always @(negedge clock) begin
        if (reset) begin
            prev_door = door_open;
            len_valid = 1'b0;
            door_len  = 0;
        end else begin
            if (door_open && !prev_door) begin
                check_output("door_expected", 32'(exp_doors.size() != 0), 32'd1);
                if (exp_doors.size() != 0) begin
                    check_output("door_floor", 32'(cur_floor), 32'(exp_doors.pop_front()));
                end
                door_len  = 1;
                len_valid = 1'b1;
            end else if (door_open) begin
                door_len++;
            end else if (prev_door && len_valid) begin
                check_output("door_len", 32'(door_len), 32'(DOOR_CYCLES));
                len_valid = 1'b0;
            end
            prev_door = door_open;
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed test sequence.
    initial begin
        reset     = 1'b1;
        stop      = 1'b0;
        call      = 4'b1111;
        cur_floor = 2'd0;

        // Reset held with all calls active.
        for (int i = 0; i < 2; i++) begin
            tick();
            check_output("rst_pending", 32'(pending), 32'h0);
            check_output("rst_tvalid", 32'(target_valid), 32'd0);
            check_output("rst_door", 32'(door_open), 32'd0);
            check_output("rst_dir", 32'(dir_up), 32'd1);
            check_output("rst_target", 32'(target), 32'd0);
        end
        reset = 1'b0;
        apply_stimulus(4'b0000, 1'b0);
        check_output("idle_pending", 32'(pending), 32'h0);

        // Single call up from floor 0 to floor 2.
        apply_stimulus(4'b0100, 1'b0);
        check_output("t1_pending", 32'(pending), 32'h4);
        check_output("t1_tvalid0", 32'(target_valid), 32'd0);
        apply_stimulus(4'b0000, 1'b0);
        check_output("t1_target", 32'(target), 32'd2);
        check_output("t1_tvalid", 32'(target_valid), 32'd1);
        check_output("t1_dir", 32'(dir_up), 32'd1);
        exp_doors.push_back(2'd2);
        cur_floor = 2'd1;
        tick();
        check_output("t1_target_f1", 32'(target), 32'd2);
        cur_floor = 2'd2;
        tick();
        check_output("t1_door", 32'(door_open), 32'd1);
        check_output("t1_pend_clr", 32'(pending), 32'h0);
        check_output("t1_tvalid_door", 32'(target_valid), 32'd0);
        for (int i = 0; i < DOOR_CYCLES - 1; i++) begin
            tick();
            check_output("t1_door_hold", 32'(door_open), 32'd1);
        end
        tick();
        check_output("t1_door_closed", 32'(door_open), 32'd0);
        check_output("t1_queue", 32'(exp_doors.size()), 32'd0);

        // Call at the current floor: straight to door, no target_valid.
        cur_floor = 2'd1;
        apply_stimulus(4'b0010, 1'b0);
        check_output("t2_pending", 32'(pending), 32'h2);
        exp_doors.push_back(2'd1);
        apply_stimulus(4'b0000, 1'b0);
        check_output("t2_door", 32'(door_open), 32'd1);
        check_output("t2_pend_clr", 32'(pending), 32'h0);
        for (int i = 0; i < DOOR_CYCLES; i++) begin
            check_output("t2_no_tvalid", 32'(target_valid), 32'd0);
            tick();
        end
        check_output("t2_door_closed", 32'(door_open), 32'd0);

        // SCAN order: moving up toward 3, pick up 2 on the way, then come back for 0.
        apply_stimulus(4'b1000, 1'b0);
        apply_stimulus(4'b0000, 1'b0);
        check_output("t3_target3", 32'(target), 32'd3);
        check_output("t3_tvalid", 32'(target_valid), 32'd1);
        apply_stimulus(4'b0101, 1'b0);
        check_output("t3_pending", 32'(pending), 32'hD);
        apply_stimulus(4'b0000, 1'b0);
        check_output("t3_retarget", 32'(target), 32'd2);
        exp_doors.push_back(2'd2);
        exp_doors.push_back(2'd3);
        exp_doors.push_back(2'd0);
        run_car(200);
        check_output("t3_dir_down", 32'(dir_up), 32'd0);
        check_output("t3_pend_empty", 32'(pending), 32'h0);

        // Emergency stop while moving up toward 3; a call for 0 arrives during the stop.
        apply_stimulus(4'b1000, 1'b0);
        apply_stimulus(4'b0000, 1'b0);
        check_output("t4_target", 32'(target), 32'd3);
        check_output("t4_dir", 32'(dir_up), 32'd1);
        cur_floor = 2'd1;
        apply_stimulus(4'b0000, 1'b1);
        check_output("t4_halt_tvalid", 32'(target_valid), 32'd0);
        check_output("t4_halt_door", 32'(door_open), 32'd0);
        apply_stimulus(4'b0001, 1'b1);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(4'b0000, 1'b1);
        end
        check_output("t4_halt_pending", 32'(pending), 32'h9);
        check_output("t4_halt_tvalid2", 32'(target_valid), 32'd0);
        apply_stimulus(4'b0000, 1'b0);
        check_output("t4_idle_tvalid", 32'(target_valid), 32'd0);
        tick();
        check_output("t4_resume_target", 32'(target), 32'd3);
        check_output("t4_resume_tvalid", 32'(target_valid), 32'd1);
        exp_doors.push_back(2'd3);
        exp_doors.push_back(2'd0);
        run_car(200);

        // Calls on every floor at once from floor 2 travelling down.
        cur_floor = 2'd2;
        tick();
        apply_stimulus(4'b1111, 1'b0);
        check_output("t5_pending", 32'(pending), 32'hF);
        call = 4'b0000;
        exp_doors.push_back(2'd2);
        exp_doors.push_back(2'd1);
        exp_doors.push_back(2'd0);
        exp_doors.push_back(2'd3);
        run_car(300);
        check_output("t5_dir_up", 32'(dir_up), 32'd1);

        // Stop asserted on the arrival cycle: halt wins and the request survives.
        apply_stimulus(4'b0010, 1'b0);
        apply_stimulus(4'b0000, 1'b0);
        check_output("t6_target", 32'(target), 32'd1);
        check_output("t6_dir", 32'(dir_up), 32'd0);
        cur_floor = 2'd2;
        tick();
        cur_floor = 2'd1;
        apply_stimulus(4'b0000, 1'b1);
        check_output("t6_halt_door", 32'(door_open), 32'd0);
        check_output("t6_halt_pending", 32'(pending), 32'h2);
        stop = 1'b0;
        exp_doors.push_back(2'd1);
        run_car(50);

        // Reset beats stop while moving down.
        apply_stimulus(4'b0001, 1'b0);
        apply_stimulus(4'b0000, 1'b0);
        check_output("t7_move_down", 32'(target_valid), 32'd1);
        check_output("t7_dir", 32'(dir_up), 32'd0);
        reset = 1'b1;
        apply_stimulus(4'b1111, 1'b1);
        check_output("t7_rst_tvalid", 32'(target_valid), 32'd0);
        check_output("t7_rst_pending", 32'(pending), 32'h0);
        check_output("t7_rst_target", 32'(target), 32'd0);
        check_output("t7_rst_dir", 32'(dir_up), 32'd1);
        reset = 1'b0;
        apply_stimulus(4'b0000, 1'b0);
        check_output("t7_post_tvalid", 32'(target_valid), 32'd0);
        check_output("t7_post_door", 32'(door_open), 32'd0);

        // Reset in the middle of a door dwell.
        apply_stimulus(4'b0010, 1'b0);
        exp_doors.push_back(2'd1);
        apply_stimulus(4'b0000, 1'b0);
        check_output("t8_door", 32'(door_open), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        check_output("t8_rst_door", 32'(door_open), 32'd0);
        check_output("t8_rst_pending", 32'(pending), 32'h0);
        reset = 1'b0;
        tick();
        check_output("t8_queue", 32'(exp_doors.size()), 32'd0);

`ifdef SERVICE_COUNT_EN
        // Service counter wraps after 256 services and ignores HALT.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_output("t9_cnt_rst", 32'(served_count), 32'd0);
        for (int i = 0; i < 257; i++) begin
            apply_stimulus(4'b0010, 1'b0);
            call = 4'b0000;
            exp_doors.push_back(2'd1);
            run_car(40);
        end
        check_output("t9_cnt_wrap", 32'(served_count), 32'd1);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(4'b0000, 1'b1);
        end
        check_output("t9_cnt_halt", 32'(served_count), 32'd1);
        apply_stimulus(4'b0000, 1'b0);
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
- Collects floor-call requests for the 4-floor car and holds them in a pending register.
- Picks the next target floor using a SCAN policy: keep the current direction while requests remain ahead, then reverse.
- Sequences door dwell time and emergency halt.
- Sits in front of the elevator FSM: drives its target, and monitors the 2-bit floor the FSM reports.

Parameters:
- DOOR_CYCLES, 4, number of clock cycles door_open stays high at each served floor (legal range 1..255).

Ports:
- clock  input  1  system clock, all logic rising-edge.
- reset  input  1  synchronous, active-high; clears all state.
- stop  input  1  emergency stop, level-sensitive.
- call  input  4  call[n]=1 requests floor n; pulse or level, sampled every cycle.
- cur_floor  input  2  current floor reported by the elevator FSM.
- target  output  2  floor the car must travel to; valid only when target_valid=1.
- target_valid  output  1  high in MOVE_UP/MOVE_DOWN.
- dir_up  output  1  1 = travelling/last travelled up, 0 = down.
- door_open  output  1  high throughout DOOR_OPEN.
- pending  output  4  registered outstanding requests.

Behaviour:
- Reset, checked on the clock edge: state=IDLE, pending=0, target=0, target_valid=0, dir_up=1, door_open=0, door timer=0.
- Pending register:
  - Every cycle, pending <= (pending | call) & ~clr.
  - clr is one-hot at cur_floor on the cycle the FSM enters DOOR_OPEN, and for the whole of DOOR_OPEN.
  - Clear wins over set, so a call for the floor being served is absorbed.
  - Latency: call at edge N is visible in pending after edge N+1.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, HALT.
- IDLE transitions, evaluated on the registered pending:
  - pending[cur_floor]=1 -> DOOR_OPEN.
  - Else any pending above cur_floor and dir_up=1 -> MOVE_UP, target = nearest pending above.
  - Else any pending below -> MOVE_DOWN, target = nearest pending below, dir_up=0.
  - Else any pending above -> MOVE_UP, dir_up=1.
  - Else stay in IDLE.
  - Tie-break: the current direction wins.
- MOVE_UP / MOVE_DOWN:
  - target_valid=1.
  - target is re-evaluated every cycle as the nearest pending floor strictly ahead of cur_floor in the travel direction, or equal to cur_floor. A new call between the car and the old target therefore retargets it (pick-up on the way).
  - cur_floor == target and pending[target]=1 -> DOOR_OPEN.
  - No pending left in the travel direction (e.g. request cancelled by reset only) -> IDLE.
- DOOR_OPEN:
  - door_open=1, target_valid=0.
  - The timer loads DOOR_CYCLES-1 on entry and decrements; door_open is high for exactly DOOR_CYCLES cycles.
  - Timer==0 -> IDLE. dir_up is retained, so SCAN continues in the same direction.
- HALT:
  - Entered from any state on the cycle after stop=1 is sampled. Stop takes priority over every other transition.
  - target_valid=0, door_open=0, timer cleared.
  - pending keeps accumulating calls.
  - stop=0 -> IDLE; service resumes from cur_floor with the retained dir_up.
- Simultaneous events:
  - stop plus arrival -> HALT; the pending bit is not cleared.
  - Calls on every floor at once are served in SCAN order.
  - reset beats stop.
- Reset mid-move or mid-door: immediate return to reset values on the next edge.
- Width rules: floors are 0..3 unsigned 2-bit; no wrap between floor 3 and floor 0.

Optional Feature:
- Macro SERVICE_COUNT_EN.
- Defined: adds output port served_count (8 bits), reset to 0.
  - Increments by 1 on each entry to DOOR_OPEN.
  - Wraps from 255 to 0.
  - Not incremented on entry to HALT.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: drive reset=1 for 2 cycles with call=4'b1111 -> all outputs 0 except dir_up=1; pending=0 while reset is held.
- Single call up: start IDLE with cur_floor=0; pulse call=4'b0100 at cycle 0.
  - Expected: pending=4'b0100 at cycle 1; target=2, target_valid=1, dir_up=1 at cycle 2.
  - Then drive cur_floor 1 then 2: DOOR_OPEN begins, door_open=1 for exactly 4 cycles, pending=0, then IDLE.
- Call at current floor: IDLE with cur_floor=1; pulse call[1] -> DOOR_OPEN with no target_valid pulse; door_open 4 cycles.
- SCAN order: moving up from floor 1 with target 3; pulse call[2] and call[0].
  - Expected: target becomes 2, served; then 3 is served; then dir_up=0 and target=0 is served.
  - Door-open floors in order: 2, 3, 0.
- Stop mid-move: in MOVE_UP toward 3, assert stop for 5 cycles and pulse call[0] during the stop.
  - Expected: HALT with target_valid=0, and pending=4'b1001 retained.
  - After release: IDLE, then MOVE_UP to 3, and floor 3 is served.
- SERVICE_COUNT_EN: perform 257 door services -> served_count reads 1; no increment during HALT.
